// File: rtl/psr_defs.sv
// Shared definitions for the program-status / exception-entry controller.
// Holds the mode codes, FSM state and exception type encodings, request bit
// indices, entry-table constants and CPSR layout.
package psr_defs;

  // Processor mode codes (CPSR[4:0])
  localparam logic [4:0] ModeUsr = 5'b10000;
  localparam logic [4:0] ModeFiq = 5'b10001;
  localparam logic [4:0] ModeIrq = 5'b10010;
  localparam logic [4:0] ModeSvc = 5'b10011;
  localparam logic [4:0] ModeMon = 5'b10110;
  localparam logic [4:0] ModeAbt = 5'b10111;
  localparam logic [4:0] ModeHyp = 5'b11010;
  localparam logic [4:0] ModeUnd = 5'b11011;
  localparam logic [4:0] ModeSys = 5'b11111;

  typedef enum logic [1:0] {
    StIdle,
    StSave,
    StLink,
    StVect
  } state_e;

  // Exception type; the encoding equals the request bit index.
  typedef enum logic [2:0] {
    ExcSvc  = 3'd0,
    ExcUnd  = 3'd1,
    ExcPabt = 3'd2,
    ExcIrq  = 3'd3,
    ExcFiq  = 3'd4,
    ExcDabt = 3'd5
  } exc_e;

  localparam int unsigned ReqSvc  = 0;
  localparam int unsigned ReqUnd  = 1;
  localparam int unsigned ReqPabt = 2;
  localparam int unsigned ReqIrq  = 3;
  localparam int unsigned ReqFiq  = 4;
  localparam int unsigned ReqDabt = 5;

  // CPSR layout
  localparam int unsigned CpsrI = 7;
  localparam int unsigned CpsrF = 6;
  localparam int unsigned CpsrT = 5;
  localparam logic [31:0] CpsrMask  = 32'hF00000FF;
  localparam logic [31:0] CpsrReset = 32'h000000D3;

  localparam int unsigned NumBanks = 7;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } bank_t;

  // Map a mode code to its SPSR bank; usr, sys and undefined codes have none.
  function automatic bank_t spsr_bank(logic [4:0] mode);
    bank_t b;
    b = '{valid: 1'b1, idx: 3'd0};
    unique case (mode)
      ModeFiq: b.idx = 3'd0;
      ModeIrq: b.idx = 3'd1;
      ModeSvc: b.idx = 3'd2;
      ModeMon: b.idx = 3'd3;
      ModeAbt: b.idx = 3'd4;
      ModeHyp: b.idx = 3'd5;
      ModeUnd: b.idx = 3'd6;
      default: b.valid = 1'b0;
    endcase
    return b;
  endfunction

  function automatic logic [4:0] exc_mode(exc_e exc);
    unique case (exc)
      ExcDabt: return ModeAbt;
      ExcFiq:  return ModeFiq;
      ExcIrq:  return ModeIrq;
      ExcPabt: return ModeAbt;
      ExcUnd:  return ModeUnd;
      default: return ModeSvc;
    endcase
  endfunction

  function automatic logic [7:0] exc_vec_off(exc_e exc);
    unique case (exc)
      ExcDabt: return 8'h10;
      ExcFiq:  return 8'h1C;
      ExcIrq:  return 8'h18;
      ExcPabt: return 8'h0C;
      ExcUnd:  return 8'h04;
      default: return 8'h08;
    endcase
  endfunction

  function automatic logic [3:0] exc_lr_off(exc_e exc);
    return (exc == ExcDabt) ? 4'd8 : 4'd4;
  endfunction

endpackage

// File: rtl/exc_prio.sv
// Exception request masking and fixed-priority selection.
//   req_i    : level requests {DAbt,FIQ,IRQ,PAbt,Und,SVC}
//   i_mask_i : CPSR.I, masks IRQ
//   f_mask_i : CPSR.F, masks FIQ
//   valid_o  : at least one unmasked request
//   type_o   : highest-priority unmasked request
module exc_prio
  import psr_defs::*;
(
  input  logic [5:0] req_i,
  input  logic       i_mask_i,
  input  logic       f_mask_i,
  output logic       valid_o,
  output exc_e       type_o
);

  logic [5:0] req_m;

  always_comb begin
    req_m          = req_i;
    req_m[ReqIrq]  = req_i[ReqIrq] & ~i_mask_i;
    req_m[ReqFiq]  = req_i[ReqFiq] & ~f_mask_i;

    valid_o = |req_m;
    type_o  = ExcSvc;
    if      (req_m[ReqDabt]) type_o = ExcDabt;
    else if (req_m[ReqFiq])  type_o = ExcFiq;
    else if (req_m[ReqIrq])  type_o = ExcIrq;
    else if (req_m[ReqPabt]) type_o = ExcPabt;
    else if (req_m[ReqUnd])  type_o = ExcUnd;
    else                     type_o = ExcSvc;
  end

endmodule

// File: rtl/psr_ctrl.sv
// Program-status and exception-entry controller. Holds CPSR and the banked
// SPSRs, drives the register file mode, and sequences exception entry as
// SAVE (SPSR save + mode switch), LINK (banked R14 write), VECT (PC write).
//   Clk, Rst            : clock, synchronous active-high reset
//   Write_NZCV/NZCV_New : ALU flag update
//   Write_CPSR/CPSR_New : MSR CPSR write
//   Write_SPSR/SPSR_New : MSR write to current mode's SPSR
//   Exc_Ret             : CPSR <= current SPSR
//   Exc_Req, PC_Cur     : exception requests and PC to link from
//   M, CPSR, SPSR, NZCV : status outputs
//   Busy                : entry sequence in progress
//   Write_LR/LR_Addr/LR_Data, Write_PC/PC_New : register-file write strobes
module psr_ctrl
  import psr_defs::*;
#(
  parameter int unsigned     SIZE     = 32,
  parameter logic [SIZE-1:0] VEC_BASE = '0
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Write_NZCV,
  input  logic [3:0]      NZCV_New,
  input  logic            Write_CPSR,
  input  logic [SIZE-1:0] CPSR_New,
  input  logic            Write_SPSR,
  input  logic [SIZE-1:0] SPSR_New,
  input  logic            Exc_Ret,
  input  logic [5:0]      Exc_Req,
  input  logic [SIZE-1:0] PC_Cur,
  output logic [4:0]      M,
  output logic [SIZE-1:0] CPSR,
  output logic [SIZE-1:0] SPSR,
  output logic [3:0]      NZCV,
  output logic            Busy,
  output logic            Write_LR,
  output logic [3:0]      LR_Addr,
  output logic [SIZE-1:0] LR_Data,
  output logic            Write_PC,
  output logic [SIZE-1:0] PC_New
);

  state_e          state_q;
  logic [31:0]     cpsr_q;
  logic [31:0]     spsr_q [NumBanks];
  exc_e            exc_q;
  logic [SIZE-1:0] pc_q;
  logic            wr_lr_q;
  logic            wr_pc_q;
  logic [SIZE-1:0] lr_data_q;
  logic [SIZE-1:0] pc_new_q;

  logic  exc_valid;
  exc_e  exc_type;
  bank_t cur_bank;
  bank_t tgt_bank;

  exc_prio u_exc_prio (
    .req_i    (Exc_Req),
    .i_mask_i (cpsr_q[CpsrI]),
    .f_mask_i (cpsr_q[CpsrF]),
    .valid_o  (exc_valid),
    .type_o   (exc_type)
  );

  always_comb begin
    cur_bank = spsr_bank(cpsr_q[4:0]);
    tgt_bank = spsr_bank(exc_mode(exc_q));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StIdle;
      cpsr_q    <= CpsrReset;
      for (int k = 0; k < NumBanks; k++) spsr_q[k] <= '0;
      exc_q     <= ExcSvc;
      pc_q      <= '0;
      wr_lr_q   <= 1'b0;
      wr_pc_q   <= 1'b0;
      lr_data_q <= '0;
      pc_new_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (exc_valid) begin
            // Accepting an exception drops every write in this cycle.
            exc_q   <= exc_type;
            pc_q    <= PC_Cur;
            state_q <= StSave;
          end else begin
            if (Exc_Ret && cur_bank.valid) begin
              cpsr_q <= spsr_q[cur_bank.idx];
            end else if (Write_CPSR) begin
              if (cpsr_q[4:0] != ModeUsr) cpsr_q <= CPSR_New[31:0] & CpsrMask;
              else                        cpsr_q[31:28] <= CPSR_New[31:28];
            end else if (Write_NZCV) begin
              cpsr_q[31:28] <= NZCV_New;
            end
            // Reads of spsr_q above see the pre-write value.
            if (Write_SPSR && cur_bank.valid) begin
              spsr_q[cur_bank.idx] <= SPSR_New[31:0] & CpsrMask;
            end
          end
        end
        StSave: begin
          // Every exception target mode is banked, so tgt_bank is always valid.
          spsr_q[tgt_bank.idx] <= cpsr_q;
          cpsr_q[4:0]          <= exc_mode(exc_q);
          cpsr_q[CpsrI]        <= 1'b1;
          cpsr_q[CpsrT]        <= 1'b0;
          if (exc_q == ExcFiq) cpsr_q[CpsrF] <= 1'b1;
          wr_lr_q   <= 1'b1;
          lr_data_q <= pc_q + SIZE'(exc_lr_off(exc_q));
          state_q   <= StLink;
        end
        StLink: begin
          wr_lr_q   <= 1'b0;
          lr_data_q <= '0;
          wr_pc_q   <= 1'b1;
          pc_new_q  <= VEC_BASE + SIZE'(exc_vec_off(exc_q));
          state_q   <= StVect;
        end
        StVect: begin
          wr_pc_q  <= 1'b0;
          pc_new_q <= '0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    M        = cpsr_q[4:0];
    CPSR     = SIZE'(cpsr_q);
    SPSR     = cur_bank.valid ? SIZE'(spsr_q[cur_bank.idx]) : '0;
    NZCV     = cpsr_q[31:28];
    Busy     = (state_q != StIdle);
    Write_LR = wr_lr_q;
    LR_Addr  = 4'd14;
    LR_Data  = lr_data_q;
    Write_PC = wr_pc_q;
    PC_New   = pc_new_q;
  end

  // Unimplemented status bits of the MSR data buses.
  logic unused_msr_bits;
  assign unused_msr_bits = ^{CPSR_New[27:8], SPSR_New[27:8]};

endmodule

// File: tb/tb_psr_ctrl.sv
// Self-checking bench for psr_ctrl. Register-file strobes are checked through
// a scoreboard: expected LR/PC writes are queued when a request is driven and
// popped by a monitor whenever the DUT strobes.
module tb_psr_ctrl;

  localparam int unsigned SIZE = 32;

  logic            Clk = 1'b0;
  logic            Rst;
  logic            Write_NZCV;
  logic [3:0]      NZCV_New;
  logic            Write_CPSR;
  logic [SIZE-1:0] CPSR_New;
  logic            Write_SPSR;
  logic [SIZE-1:0] SPSR_New;
  logic            Exc_Ret;
  logic [5:0]      Exc_Req;
  logic [SIZE-1:0] PC_Cur;
  logic [4:0]      M;
  logic [SIZE-1:0] CPSR;
  logic [SIZE-1:0] SPSR;
  logic [3:0]      NZCV;
  logic            Busy;
  logic            Write_LR;
  logic [3:0]      LR_Addr;
  logic [SIZE-1:0] LR_Data;
  logic            Write_PC;
  logic [SIZE-1:0] PC_New;

  psr_ctrl #(
    .SIZE     (SIZE),
    .VEC_BASE (32'h00000000)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Write_NZCV (Write_NZCV),
    .NZCV_New   (NZCV_New),
    .Write_CPSR (Write_CPSR),
    .CPSR_New   (CPSR_New),
    .Write_SPSR (Write_SPSR),
    .SPSR_New   (SPSR_New),
    .Exc_Ret    (Exc_Ret),
    .Exc_Req    (Exc_Req),
    .PC_Cur     (PC_Cur),
    .M          (M),
    .CPSR       (CPSR),
    .SPSR       (SPSR),
    .NZCV       (NZCV),
    .Busy       (Busy),
    .Write_LR   (Write_LR),
    .LR_Addr    (LR_Addr),
    .LR_Data    (LR_Data),
    .Write_PC   (Write_PC),
    .PC_New     (PC_New)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          is_pc;
    logic [31:0] data;
  } strobe_t;

  strobe_t sb_q[$];

  // Strobe monitor, sampled on the falling edge.
  always @(negedge Clk) begin
    strobe_t e;
    if (Write_LR || Write_PC) begin
      check_eq("strobe_excl", {31'b0, Write_LR & Write_PC}, 32'd0);
      if (sb_q.size() == 0) begin
        check_eq("strobe_unexpected", {30'b0, Write_PC, Write_LR}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("strobe_kind", {31'b0, Write_PC}, {31'b0, e.is_pc});
        if (e.is_pc) begin
          check_eq("pc_new", PC_New, e.data);
        end else begin
          check_eq("lr_data", LR_Data, e.data);
          check_eq("lr_addr", {28'b0, LR_Addr}, 32'd14);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Write_NZCV = 1'b0;
    NZCV_New   = '0;
    Write_CPSR = 1'b0;
    CPSR_New   = '0;
    Write_SPSR = 1'b0;
    SPSR_New   = '0;
    Exc_Ret    = 1'b0;
    Exc_Req    = '0;
  endtask

  task automatic write_cpsr(input logic [31:0] val);
    CPSR_New   = val;
    Write_CPSR = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic exc_return();
    Exc_Ret = 1'b1;
    tick();
    clear_inputs();
  endtask

  // Drive a request, expect a full entry with the given link and vector.
  task automatic run_exc(input logic [5:0] req, input logic [31:0] pc,
                         input logic [31:0] lr, input logic [31:0] vec);
    int busy_cnt;
    sb_q.push_back('{is_pc: 1'b0, data: lr});
    sb_q.push_back('{is_pc: 1'b1, data: vec});
    Exc_Req = req;
    PC_Cur  = pc;
    tick();
    Exc_Req  = '0;
    busy_cnt = 0;
    while (Busy && busy_cnt < 10) begin
      busy_cnt++;
      tick();
    end
    check_eq("busy_cycles", busy_cnt, 32'd3);
  endtask

  initial begin
    clear_inputs();
    PC_Cur = '0;
    Rst    = 1'b1;
    tick();
    tick();
    Rst = 1'b0;

    // Reset state
    check_eq("rst_cpsr", CPSR, 32'h000000D3);
    check_eq("rst_m", {27'b0, M}, 32'h13);
    check_eq("rst_spsr", SPSR, 32'h0);
    check_eq("rst_busy", {31'b0, Busy}, 32'h0);
    check_eq("rst_strobes", {30'b0, Write_PC, Write_LR}, 32'h0);
    check_eq("rst_lr_pc_data", LR_Data | PC_New, 32'h0);

    // IRQ masked by I=1
    Exc_Req = 6'b001000;
    tick();
    clear_inputs();
    check_eq("irq_masked_busy", {31'b0, Busy}, 32'h0);
    check_eq("irq_masked_cpsr", CPSR, 32'h000000D3);

    // MSR in svc, then in usr (flags only)
    write_cpsr(32'h00000010);
    check_eq("msr_svc_cpsr", CPSR, 32'h00000010);
    check_eq("msr_svc_m", {27'b0, M}, 32'h10);
    write_cpsr(32'hF00000D3);
    check_eq("msr_usr_cpsr", CPSR, 32'hF0000010);
    check_eq("usr_spsr", SPSR, 32'h0);

    // ALU flag update
    NZCV_New   = 4'h5;
    Write_NZCV = 1'b1;
    tick();
    clear_inputs();
    check_eq("nzcv_update", CPSR, 32'h50000010);
    check_eq("nzcv_out", {28'b0, NZCV}, 32'h5);
    write_cpsr(32'h00000010);
    check_eq("usr_clear_flags", CPSR, 32'h00000010);

    // IRQ from usr
    run_exc(6'b001000, 32'h00000100, 32'h00000104, 32'h00000018);
    check_eq("irq_cpsr", CPSR, 32'h00000092);
    check_eq("irq_spsr", SPSR, 32'h00000010);
    exc_return();
    check_eq("irq_ret_cpsr", CPSR, 32'h00000010);

    // FIQ wins over IRQ and SVC
    run_exc(6'b011001, 32'h00000300, 32'h00000304, 32'h0000001C);
    check_eq("fiq_cpsr", CPSR, 32'h000000D1);
    check_eq("fiq_spsr", SPSR, 32'h00000010);
    exc_return();
    check_eq("fiq_ret_cpsr", CPSR, 32'h00000010);

    // DAbt with link wrap
    run_exc(6'b100000, 32'hFFFFFFFC, 32'h00000004, 32'h00000010);
    check_eq("dabt_m", {27'b0, M}, 32'h17);
    check_eq("dabt_cpsr", CPSR, 32'h00000097);
    exc_return();
    check_eq("dabt_ret_cpsr", CPSR, 32'h00000010);

    // Reset during LINK: LR strobe happens, PC strobe never does
    sb_q.push_back('{is_pc: 1'b0, data: 32'h00000204});
    Exc_Req = 6'b000001;
    PC_Cur  = 32'h00000200;
    tick();
    clear_inputs();
    tick();
    check_eq("link_m_svc", {27'b0, M}, 32'h13);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check_eq("abort_busy", {31'b0, Busy}, 32'h0);
    check_eq("abort_cpsr", CPSR, 32'h000000D3);
    for (int i = 0; i < 4; i++) tick();

    // sys mode: SPSR absent, Exc_Ret ignored
    write_cpsr(32'h0000001F);
    check_eq("sys_cpsr", CPSR, 32'h0000001F);
    SPSR_New   = 32'h12345678;
    Write_SPSR = 1'b1;
    tick();
    clear_inputs();
    check_eq("sys_spsr", SPSR, 32'h0);
    exc_return();
    check_eq("sys_ret_cpsr", CPSR, 32'h0000001F);

    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psr_ctrl.md
Name: psr_ctrl

Overview:
- Program-status and exception-entry controller that sits directly upstream of the banked multi-mode register file.
- Holds CPSR and the banked SPSRs, and drives the register file's 5-bit mode input M.
- On an accepted exception it sequences SPSR save, mode switch, a banked LR write and the PC vector write.
- Also handles MSR-style CPSR/SPSR writes, ALU flag updates and exception return.

Parameters:
- SIZE, 32, data/PC width.
- VEC_BASE, 32'h00000000, exception vector table base.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset
- Write_NZCV  in  1  ALU flag update (S-suffixed instruction)
- NZCV_New  in  4  new N,Z,C,V
- Write_CPSR  in  1  MSR CPSR write
- CPSR_New  in  SIZE  MSR CPSR data
- Write_SPSR  in  1  MSR SPSR write (current mode's SPSR)
- SPSR_New  in  SIZE  MSR SPSR data
- Exc_Ret  in  1  exception return: CPSR <= current SPSR
- Exc_Req  in  6  level requests {DAbt,FIQ,IRQ,PAbt,Und,SVC}, bit5..bit0
- PC_Cur  in  SIZE  PC value from register file
- M  out  5  CPSR[4:0], to register file
- CPSR  out  SIZE  full CPSR
- SPSR  out  SIZE  current-mode SPSR
- NZCV  out  4  CPSR[31:28]
- Busy  out  1  exception sequence in progress; upstream stalls
- Write_LR  out  1  register-file write strobe for R14
- LR_Addr  out  4  constant 4'd14
- LR_Data  out  SIZE  link value
- Write_PC  out  1  register-file PC write strobe
- PC_New  out  SIZE  vector address

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- CPSR implemented bits: [31:28] NZCV, [7] I, [6] F, [5] T, [4:0] M. All other bits read 0 and writes to them are ignored.
- Reset (Rst=1 at posedge):
  - CPSR = 32'h000000D3 (svc, I=1, F=1).
  - All SPSRs = 0.
  - State = IDLE.
  - Busy, Write_LR and Write_PC = 0.
  - Reset mid-sequence aborts it: no further LR/PC strobes are issued.
- Mode codes:
  - usr 10000, fiq 10001, irq 10010, svc 10011, mon 10110, abt 10111, hyp 11010, und 11011, sys 11111.
  - SPSR is banked for fiq, irq, svc, mon, abt, hyp and und.
  - In usr, sys or an undefined mode code: SPSR reads 0, Write_SPSR is ignored, Exc_Ret is ignored.
- Masking: IRQ is masked when I=1; FIQ is masked when F=1.
- Priority among unmasked requests: DAbt > FIQ > IRQ > PAbt > Und > SVC.
- Entry table (target mode / vector offset / LR offset):
  - DAbt: abt / 0x10 / +8
  - FIQ: fiq / 0x1C / +4
  - IRQ: irq / 0x18 / +4
  - PAbt: abt / 0x0C / +4
  - Und: und / 0x04 / +4
  - SVC: svc / 0x08 / +4
- FSM states: IDLE, SAVE, LINK, VECT.
- IDLE:
  - If any unmasked request is present: latch the selected type and PC_Cur, go to SAVE. All writes in that same cycle are dropped.
  - Else, Exc_Ret (valid mode): CPSR <= SPSR.
  - Else, Write_CPSR: in privileged mode update all implemented bits; in usr update NZCV only.
  - Else, Write_NZCV: update NZCV only.
  - Write_SPSR is independent of the above and applies in the same cycle, unless an exception is accepted.
- SAVE (Busy=1):
  - At the next edge: SPSR_target <= CPSR; M <= target mode; I <= 1; T <= 0; F <= 1 only for FIQ.
  - Go to LINK.
- LINK (Busy=1):
  - M already reflects the new mode, so the register file banks R14 correctly.
  - Write_LR=1; LR_Data = latched PC + LR offset, modulo 2^SIZE.
  - Go to VECT.
- VECT (Busy=1):
  - Write_PC=1; PC_New = VEC_BASE + vector offset.
  - Go to IDLE.
- Write_LR and Write_PC are decoded from the state register, are never asserted together, and are 0 outside LINK/VECT. LR_Data and PC_New are 0 when not strobed.
- While Busy=1, all input writes and requests are ignored. Requests are level-sampled again in IDLE, so an entry latency is exactly 3 Busy cycles.
- A new FIQ can be accepted in the first IDLE cycle after an IRQ entry completes; that FIQ entry overwrites LR_fiq and SPSR_fiq only.

Decomposition:
- Package psr_defs holds:
  - mode codes, state encoding, request bit indices;
  - vector offsets, LR offsets, CPSR bit positions;
  - reset CPSR constant.
- Sub-module exc_prio: combinational masking plus priority encoder (6-bit Exc_Req, I, F) -> {valid, 3-bit type}.

Test Plan:
- Reset -> CPSR=0x000000D3, M=10011, SPSR=0, Busy=0. Then Exc_Req IRQ with I=1 -> no state change.
- Write_CPSR 0x00000010 in svc -> M=10000, I=F=0. Then Write_CPSR 0xF00000D3 in usr -> CPSR=0xF0000010.
- From usr CPSR=0x10, IRQ, PC_Cur=0x100:
  - Busy high for 3 cycles.
  - SPSR_irq=0x10, CPSR=0x92.
  - LINK: Write_LR, LR_Data=0x104.
  - VECT: Write_PC, PC_New=0x18.
- FIQ+IRQ+SVC together from usr -> FIQ taken; CPSR=0xD1, PC_New=0x1C. Then Exc_Ret -> CPSR=0x10.
- DAbt, PC_Cur=0xFFFFFFFC -> LR_Data=0x00000004 (wrap); PC_New=0x10; M=10111.
- Rst asserted during LINK -> next cycle IDLE, CPSR=0xD3, no Write_PC ever. Write_SPSR in sys -> SPSR stays 0.
